ffn_cfg_loader: RTL
===================

# ffn_cfg_loader

Streaming initiator for the feed-forward block's configuration write port. Accepts a flat ready/valid stream of signed weight/bias words from the host or DMA side and turns it into sequential single-word writes on the cfg_we / cfg_addr / cfg_wdata port of the FFN. It sits between the parameter-load fabric and one FFN instance. It sequences the four regions W1, b1, W2, b2, checks stream framing, and reports completion and a running checksum.

## Interface
Parameters:
- EMB, 64, embedding width.
- FF, 256, hidden width.
- DATA_W, 16, signed word width.
- TOTAL (localparam), EMB*FF + FF + FF*EMB + EMB, number of words in one full load.
- ADDR_W (localparam), $clog2(TOTAL), config address width; matches the FFN cfg_addr width.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle load request; honoured only in IDLE.
- s_valid  in  1  stream word valid.
- s_ready  out  1  stream word accepted when s_valid && s_ready.
- s_data  in  DATA_W  signed stream word.
- s_last  in  1  marks the final word of a load.
- cfg_we  out  1  config write strobe to the FFN.
- cfg_addr  out  ADDR_W  config write address.
- cfg_wdata  out  DATA_W  config write data.
- section  out  2  region of the current cfg_addr: 0 = W1, 1 = b1, 2 = W2, 3 = b2.
- busy  out  1  high while a load is in progress.
- done  out  1  one-cycle pulse when a load ends, whether completed or aborted.
- err  out  1  framing error flag; sticky until the next accepted start.
- chk_sum  out  32  wrap-around sum of sign-extended accepted words for the current load.

## Operation
- States:
  - IDLE: s_ready=0. On start, go to LOAD, clear word counter, err and chk_sum.
  - LOAD: s_ready=1. Each accepted beat is written to cfg_addr = counter and cfg_wdata = s_data. chk_sum += sign-extended s_data. Counter increments.
  - Return to IDLE.
- Completion, accepted beat with counter == TOTAL-1:
  - s_last=1: clean finish, err stays 0.
  - s_last=0: err=1.
  - Either case: the write is issued, then the block returns to IDLE with done pulsed.
- Early s_last, accepted with counter < TOTAL-1: the word is written, err=1, the block returns to IDLE with done pulsed. Later addresses are not written.
- start during LOAD is ignored. start and a beat arriving in the same IDLE cycle: the beat is not accepted, because s_ready is 0.
- s_valid gaps in LOAD are allowed. No write occurs in a cycle without an accepted beat.
- Regions by cfg_addr:
  - W1: [0, EMB*FF)
  - b1: [EMB*FF, EMB*FF+FF)
  - W2: [EMB*FF+FF, 2*EMB*FF+FF)
  - b2: [2*EMB*FF+FF, TOTAL)
- section is registered alongside cfg_addr. The counter never exceeds TOTAL-1 and does not wrap.
- chk_sum wraps modulo 2^32 and holds its value after done until the next start.
- rst mid-load: the load is abandoned, all state clears, and no further cfg_we is issued. The FFN contents are then partial and must be reloaded.

## Timing
- Reset values: s_ready=0, cfg_we=0, cfg_addr=0, cfg_wdata=0, section=0, busy=0, done=0, err=0, chk_sum=0.
- start sampled at cycle N gives busy=1 and s_ready=1 from N+1.
- Beat accepted at cycle N gives cfg_we=1 with its address and data at N+1, so write latency is 1. chk_sum updates at N+1.
- Final or early-last beat accepted at N:
  - At N+1: done=1 and err valid, in the same cycle as the final cfg_we. busy=0 and s_ready=0.
  - At N+2: done=0.
- Back-to-back: one write per cycle at full stream rate, so a full load takes TOTAL+1 cycles from the first beat to done.
- cfg_addr and cfg_wdata hold their last values when cfg_we=0.

## Structure
- Shared transformer package holds:
  - an FFN config-size function: TOTAL from EMB and FF.
  - the region base offsets as functions of EMB and FF.
  - a 2-bit ffn_cfg_section_t enum: W1, b1, W2, b2.
  - the loader state enum.
- The FFN cfg_addr width must be derived from the same package function.
- A small sub-module, ffn_cfg_section_dec, is natural: it maps an address to ffn_cfg_section_t using the package offsets and is reusable on the FFN receive side.

## Test plan
All scenarios use EMB=2, FF=4, giving TOTAL=22 and ADDR_W=5.
- Reset, then idle 5 cycles -> all outputs 0, s_ready=0.
- start, then 22 back-to-back words 1..22 with s_last on word 22:
  - cfg_we for 22 consecutive cycles, addr 0..21, data 1..22.
  - section 0 at addr 0–7, 1 at 8–11, 2 at 12–19, 3 at 20–21.
  - done in the same cycle as addr 21; err=0; chk_sum=253.
- Same load with s_valid toggling every other cycle -> identical write sequence with matching gaps, done one cycle after the last beat.
- s_last on word 10 -> writes at addr 0..9 only, err=1, done pulses, busy=0, and a subsequent beat is not accepted.
- 22 words with s_last=0 on word 22 -> all 22 writes, err=1. A following start clears err.
- Words -1 (0xFFFF) ×22 -> chk_sum=0xFFFFFFEA.
- rst asserted after 5 writes -> no cfg_we on the next cycle, all outputs at reset values.
- start pulsed during LOAD -> no effect on the counter.

Source files
------------

// File: rtl/ffn_cfg_loader_pkg.sv
// Shared FFN configuration layout: region offsets, total size, section and loader-state enums.
package ffn_cfg_loader_pkg;

   localparam int unsigned CHK_W = 32;

   typedef enum logic [1:0] {
      SEC_W1 = 2'd0,
      SEC_B1 = 2'd1,
      SEC_W2 = 2'd2,
      SEC_B2 = 2'd3
   } ffn_cfg_section_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOAD = 1'b1
   } ffn_cfg_ld_state_t;

   function automatic int unsigned ffn_cfg_b1_base(int unsigned emb, int unsigned ff);
      return emb * ff;
   endfunction

   function automatic int unsigned ffn_cfg_w2_base(int unsigned emb, int unsigned ff);
      return emb * ff + ff;
   endfunction

   function automatic int unsigned ffn_cfg_b2_base(int unsigned emb, int unsigned ff);
      return 2 * emb * ff + ff;
   endfunction

   function automatic int unsigned ffn_cfg_total(int unsigned emb, int unsigned ff);
      return emb * ff + ff + ff * emb + emb;
   endfunction

   // Address width shared with the FFN receive side.
   function automatic int unsigned ffn_cfg_addr_w(int unsigned emb, int unsigned ff);
      return $clog2(ffn_cfg_total(emb, ff));
   endfunction

endpackage

// File: rtl/ffn_cfg_loader_if.sv
// Ready/valid parameter stream from the load fabric into the config loader.
interface ffn_cfg_loader_if #(
   parameter int unsigned DATA_W = 16
);
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              s_last;

   modport master (output s_valid, output s_data, output s_last, input s_ready);
   modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/ffn_cfg_section_dec.sv
// Maps an FFN config address to its parameter region.
module ffn_cfg_section_dec
   import ffn_cfg_loader_pkg::*;
#(
   parameter int unsigned EMB    = 64,
   parameter int unsigned FF     = 256,
   parameter int unsigned ADDR_W = ffn_cfg_addr_w(EMB, FF)
) (
   input  logic [ADDR_W-1:0] addr,
   output ffn_cfg_section_t  section_c
);

   localparam int unsigned B1_BASE = ffn_cfg_b1_base(EMB, FF);
   localparam int unsigned W2_BASE = ffn_cfg_w2_base(EMB, FF);
   localparam int unsigned B2_BASE = ffn_cfg_b2_base(EMB, FF);

   always_comb begin
      section_c = SEC_W1;
      if (32'(addr) >= B2_BASE)      section_c = SEC_B2;
      else if (32'(addr) >= W2_BASE) section_c = SEC_W2;
      else if (32'(addr) >= B1_BASE) section_c = SEC_B1;
   end

endmodule

// File: rtl/ffn_cfg_loader.sv
// Streams W1/b1/W2/b2 words into the FFN config write port with framing check and checksum.
module ffn_cfg_loader
   import ffn_cfg_loader_pkg::*;
#(
   parameter int unsigned EMB    = 64,
   parameter int unsigned FF     = 256,
   parameter int unsigned DATA_W = 16,
   localparam int unsigned TOTAL  = ffn_cfg_total(EMB, FF),
   localparam int unsigned ADDR_W = ffn_cfg_addr_w(EMB, FF)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   ffn_cfg_loader_if.slave        s,
   output logic                   cfg_we,
   output logic [ADDR_W-1:0]      cfg_addr,
   output logic [DATA_W-1:0]      cfg_wdata,
   output ffn_cfg_section_t       section,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [CHK_W-1:0]       chk_sum
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

   ffn_cfg_ld_state_t state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              ready_d, we_d, busy_d, done_d, err_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d;
   ffn_cfg_section_t  section_d, sec_c;
   logic [CHK_W-1:0]  chk_d, data_ext_c;
   logic              last_word_c;

   ffn_cfg_section_dec #(.EMB(EMB), .FF(FF), .ADDR_W(ADDR_W)) u_sec_dec (
      .addr      (cnt_q),
      .section_c (sec_c)
   );

   assign data_ext_c  = {{(CHK_W - DATA_W){s.s_data[DATA_W-1]}}, s.s_data};
   assign last_word_c = (cnt_q == LAST_ADDR);

   // Next-state and registered-output values.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = 1'b0;
      addr_d    = cfg_addr;
      wdata_d   = cfg_wdata;
      section_d = section;
      done_d    = 1'b0;
      err_d     = err;
      chk_d     = chk_sum;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
               err_d   = 1'b0;
               chk_d   = '0;
            end
         end
         ST_LOAD: begin
            if (s.s_valid && s.s_ready) begin
               we_d      = 1'b1;
               addr_d    = cnt_q;
               wdata_d   = s.s_data;
               section_d = sec_c;
               chk_d     = chk_sum + data_ext_c;
               if (s.s_last || last_word_c) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                  err_d   = !(s.s_last && last_word_c);
               end else begin
                  cnt_d = cnt_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      ready_d = (state_d == ST_LOAD);
      busy_d  = (state_d == ST_LOAD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         s.s_ready <= 1'b0;
         cfg_we    <= 1'b0;
         cfg_addr  <= '0;
         cfg_wdata <= '0;
         section   <= SEC_W1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         chk_sum   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         s.s_ready <= ready_d;
         cfg_we    <= we_d;
         cfg_addr  <= addr_d;
         cfg_wdata <= wdata_d;
         section   <= section_d;
         busy      <= busy_d;
         done      <= done_d;
         err       <= err_d;
         chk_sum   <= chk_d;
      end
   end

endmodule
